// File: rtl/fir_transpose_param.sv
// Transposed-form FIR with a runtime coefficient bank and a rounding/saturating output stage.
// Latency: sample taken at edge t appears after edge t+2; one sample per clock, valid-only (no backpressure).
module fir_transpose_param #(
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int NTAPS = 7,
    parameter int ACCW  = DW + CW + $clog2(NTAPS),
    parameter int OW    = 16,
    parameter int SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic signed [DW-1:0]       x_in,
    input  logic                       flush,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [CW-1:0]       coef_data,
    output logic                       out_valid,
    output logic signed [OW-1:0]       y_out,
    output logic                       sat_flag
);

    localparam int AW = $clog2(NTAPS);
    localparam logic signed [ACCW:0] YMAX = (ACCW+1)'((64'sd1 <<< (OW-1)) - 64'sd1);
    localparam logic signed [ACCW:0] YMIN = (ACCW+1)'(-(64'sd1 <<< (OW-1)));

    logic signed [CW-1:0]   r_coef [NTAPS];
    logic signed [DW-1:0]   r_xq;
    logic signed [ACCW-1:0] r_p [NTAPS];
    logic                   r_v1;
    logic                   r_v2;

    logic signed [ACCW-1:0] w_xq_ext;
    logic signed [ACCW-1:0] w_c_ext [NTAPS];
    logic signed [ACCW-1:0] w_prod [NTAPS];
    logic signed [ACCW:0]   w_ext;
    logic signed [ACCW:0]   w_rnd;
    logic signed [ACCW:0]   w_sh;
    logic signed [OW-1:0]   w_y;
    logic                   w_sat;

    // Addresses with no matching tap simply match nothing, so they are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NTAPS; j++) r_coef[j] <= '0;
        end else if (coef_we) begin
            for (int j = 0; j < NTAPS; j++) begin
                if (coef_addr == AW'(j)) r_coef[j] <= coef_data;
            end
        end
    end

    assign w_xq_ext = {{(ACCW-DW){r_xq[DW-1]}}, r_xq};

    for (genvar j = 0; j < NTAPS; j++) begin : g_mul
        assign w_c_ext[j] = {{(ACCW-CW){r_coef[j][CW-1]}}, r_coef[j]};
        assign w_prod[j]  = w_xq_ext * w_c_ext[j];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xq <= '0;
            r_v1 <= 1'b0;
        end else if (flush) begin
            r_xq <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) r_xq <= x_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NTAPS; j++) r_p[j] <= '0;
            r_v2 <= 1'b0;
        end else if (flush) begin
            for (int j = 0; j < NTAPS; j++) r_p[j] <= '0;
            r_v2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_p[0] <= w_prod[0];
                for (int j = 1; j < NTAPS; j++) r_p[j] <= w_prod[j] + r_p[j-1];
            end
        end
    end

    // One guard bit above the accumulator keeps the rounding bias from wrapping.
    assign w_ext = {r_p[NTAPS-1][ACCW-1], r_p[NTAPS-1]};

    if (SHIFT > 0) begin : g_rnd
        localparam logic signed [ACCW:0] RND_BIAS = (ACCW+1)'(64'sd1 <<< (SHIFT-1));
        assign w_rnd = w_ext + RND_BIAS;
    end else begin : g_nornd
        assign w_rnd = w_ext;
    end

    assign w_sh = w_rnd >>> SHIFT;

    always_comb begin
        w_y   = w_sh[OW-1:0];
        w_sat = 1'b0;
        if (w_sh > YMAX) begin
            w_y   = YMAX[OW-1:0];
            w_sat = 1'b1;
        end else if (w_sh < YMIN) begin
            w_y   = YMIN[OW-1:0];
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y_out     <= '0;
            sat_flag  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_v2;
            if (r_v2) begin
                y_out    <= w_y;
                sat_flag <= w_sat;
            end
        end
    end

endmodule

// File: tb/tb_fir_transpose_param.sv
// Directed bench for fir_transpose_param: unshifted and SHIFT=7 instances share one stimulus.
module tb_fir_transpose_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid;
    logic signed [7:0] x_in;
    logic              flush;
    logic              coef_we;
    logic [2:0]        coef_addr;
    logic signed [7:0] coef_data;
    logic              out_valid0, sat0, out_valid7, sat7;
    logic signed [15:0] y0, y7;

    int total = 0;
    int bad   = 0;

    logic signed [7:0]  sx [64];
    logic               sv [64];
    logic               sf [64];
    logic               vpat [64];
    logic signed [15:0] q0 [$];
    logic signed [15:0] q7 [$];
    logic               qs0 [$];

    logic signed [15:0] e_imp [7] = '{-16'sd2, 16'sd0, 16'sd34, 16'sd64, 16'sd34, 16'sd0, -16'sd2};
    logic signed [15:0] e_rnd [7] = '{16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd0};
    logic signed [15:0] e_upd [7] = '{-16'sd2, 16'sd0, 16'sd34, 16'sd10, 16'sd34, 16'sd0, -16'sd2};
    logic signed [15:0] e_pos [10] = '{16'sd16129, 16'sd32258, 16'sd32767, 16'sd32767, 16'sd32767,
                                       16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};
    logic signed [15:0] e_neg [10] = '{-16'sd16256, -16'sd32512, -16'sd32768, -16'sd32768, -16'sd32768,
                                       -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768};

    fir_transpose_param #(.SHIFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x_in(x_in), .flush(flush),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid0), .y_out(y0), .sat_flag(sat0)
    );

    fir_transpose_param #(.SHIFT(7)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x_in(x_in), .flush(flush),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid7), .y_out(y7), .sat_flag(sat7)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [2:0] a, input logic signed [7:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        tick();
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    endtask

    task automatic load_impulse_coefs();
        for (int j = 0; j < 7; j++) write_coef(3'(j), 8'(e_imp[j]));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 64; i++) begin
            sx[i] = '0; sv[i] = 1'b0; sf[i] = 1'b0; vpat[i] = 1'b0;
        end
    endtask

    task automatic impulse_stim();
        clear_stim();
        for (int c = 0; c < 7; c++) sv[c] = 1'b1;
        sx[0] = 8'sd1;
    endtask

    // Drives the stimulus tables and records every out_valid-qualified output.
    task automatic run(input int n);
        q0.delete(); q7.delete(); qs0.delete();
        for (int c = 0; c < n; c++) begin
            in_valid = sv[c]; x_in = sx[c]; flush = sf[c];
            tick();
            vpat[c] = out_valid0;
            if (out_valid0) begin
                q0.push_back(y0);
                qs0.push_back(sat0);
            end
            if (out_valid7) q7.push_back(y7);
        end
        in_valid = 1'b0; x_in = '0; flush = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (out_valid0 !== 1'b0 || y0 !== 16'sd0 || sat0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b y=%0d s=%b want v=0 y=0 s=0", out_valid0, y0, sat0);
        end
        total++;
        if (out_valid7 !== 1'b0 || y7 !== 16'sd0) begin
            bad++;
            $display("FAIL reset_outputs_r got v=%b y=%0d want v=0 y=0", out_valid7, y7);
        end
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_impulse();
        logic signed [15:0] g;
        load_impulse_coefs();
        do_flush();
        impulse_stim();
        run(9);
        for (int c = 0; c < 9; c++) begin
            total++;
            if (vpat[c] !== (c >= 2)) begin
                bad++;
                $display("FAIL imp_valid[%0d] got=%b want=%b", c, vpat[c], (c >= 2));
            end
        end
        for (int i = 0; i < 7; i++) begin
            g = 'x;
            if (i < q0.size()) g = q0[i];
            total++;
            if (g !== e_imp[i] || (i < qs0.size() && qs0[i] !== 1'b0)) begin
                bad++;
                $display("FAIL imp_y[%0d] got=%0d want=%0d", i, g, e_imp[i]);
            end
            g = 'x;
            if (i < q7.size()) g = q7[i];
            total++;
            if (g !== e_rnd[i]) begin
                bad++;
                $display("FAIL rnd_y[%0d] got=%0d want=%0d", i, g, e_rnd[i]);
            end
        end
    endtask

    task automatic test_bubbles();
        logic signed [15:0] g;
        do_flush();
        clear_stim();
        for (int c = 0; c < 14; c++) begin
            sv[c] = (c % 2 == 0);
            sx[c] = sv[c] ? 8'sd0 : 8'sh55;
        end
        sx[0] = 8'sd1;
        run(16);
        for (int c = 0; c < 16; c++) begin
            total++;
            if (vpat[c] !== ((c >= 2) ? sv[c-2] : 1'b0)) begin
                bad++;
                $display("FAIL bub_valid[%0d] got=%b want=%b", c, vpat[c], (c >= 2) ? sv[c-2] : 1'b0);
            end
        end
        total++;
        if (q0.size() != 7) begin
            bad++;
            $display("FAIL bub_count got=%0d want=7", q0.size());
        end
        for (int i = 0; i < 7; i++) begin
            g = 'x;
            if (i < q0.size()) g = q0[i];
            total++;
            if (g !== e_imp[i]) begin
                bad++;
                $display("FAIL bub_y[%0d] got=%0d want=%0d", i, g, e_imp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] g;
        for (int j = 0; j < 7; j++) write_coef(3'(j), 8'sd127);
        for (int pass = 0; pass < 2; pass++) begin
            do_flush();
            clear_stim();
            for (int c = 0; c < 10; c++) begin
                sv[c] = 1'b1;
                sx[c] = (pass == 0) ? 8'sd127 : -8'sd128;
            end
            run(12);
            for (int i = 0; i < 10; i++) begin
                g = 'x;
                if (i < q0.size()) g = q0[i];
                total++;
                if (g !== ((pass == 0) ? e_pos[i] : e_neg[i]) || i >= qs0.size() || qs0[i] !== (i >= 2)) begin
                    bad++;
                    $display("FAIL sat_y[%0d][%0d] got=%0d want=%0d sat_want=%b", pass, i, g,
                             (pass == 0) ? e_pos[i] : e_neg[i], (i >= 2));
                end
            end
            g = 'x;
            if (q7.size() == 10) g = q7[9];
            total++;
            if (g !== ((pass == 0) ? 16'sd882 : -16'sd889)) begin
                bad++;
                $display("FAIL sat_rnd[%0d] got=%0d want=%0d", pass, g, (pass == 0) ? 16'sd882 : -16'sd889);
            end
        end
    endtask

    task automatic test_flush();
        logic signed [15:0] g;
        load_impulse_coefs();
        do_flush();
        clear_stim();
        sv[0] = 1'b1; sv[1] = 1'b1; sv[2] = 1'b1; sx[0] = 8'sd1;
        sv[3] = 1'b1; sx[3] = 8'sd5; sf[3] = 1'b1;
        run(7);
        for (int c = 0; c < 7; c++) begin
            total++;
            if (vpat[c] !== (c == 2)) begin
                bad++;
                $display("FAIL flush_valid[%0d] got=%b want=%b", c, vpat[c], (c == 2));
            end
        end
        total++;
        if (y0 !== -16'sd2 || sat0 !== 1'b0) begin
            bad++;
            $display("FAIL flush_hold got y=%0d s=%b want y=-2 s=0", y0, sat0);
        end
        impulse_stim();
        run(9);
        total++;
        if (q0.size() != 7) begin
            bad++;
            $display("FAIL flush_count got=%0d want=7", q0.size());
        end
        for (int i = 0; i < 7; i++) begin
            g = 'x;
            if (i < q0.size()) g = q0[i];
            total++;
            if (g !== e_imp[i]) begin
                bad++;
                $display("FAIL flush_y[%0d] got=%0d want=%0d", i, g, e_imp[i]);
            end
        end
    endtask

    task automatic test_coef_update();
        logic signed [15:0] g;
        // Write coincides with flush and a dropped sample.
        coef_we = 1'b1; coef_addr = 3'd3; coef_data = 8'sd10;
        flush = 1'b1; in_valid = 1'b1; x_in = 8'sd7;
        tick();
        coef_we = 1'b0; flush = 1'b0; in_valid = 1'b0; x_in = '0;
        write_coef(3'd7, 8'sd99);
        impulse_stim();
        run(9);
        total++;
        if (q0.size() != 7) begin
            bad++;
            $display("FAIL upd_count got=%0d want=7", q0.size());
        end
        for (int i = 0; i < 7; i++) begin
            g = 'x;
            if (i < q0.size()) g = q0[i];
            total++;
            if (g !== e_upd[i]) begin
                bad++;
                $display("FAIL upd_y[%0d] got=%0d want=%0d", i, g, e_upd[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [15:0] g;
        in_valid = 1'b1; x_in = 8'sd1;
        tick();
        in_valid = 1'b1; x_in = 8'sd0;
        tick();
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid0 !== 1'b1 || y0 !== -16'sd2) begin
            bad++;
            $display("FAIL rstmid_pre got v=%b y=%0d want v=1 y=-2", out_valid0, y0);
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid0 !== 1'b0 || y0 !== 16'sd0 || sat0 !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async got v=%b y=%0d s=%b want v=0 y=0 s=0", out_valid0, y0, sat0);
        end
        #2 rst_n = 1'b1;
        tick();
        impulse_stim();
        run(9);
        total++;
        if (q0.size() != 7 || q7.size() != 7) begin
            bad++;
            $display("FAIL rstmid_count got=%0d/%0d want=7/7", q0.size(), q7.size());
        end
        for (int i = 0; i < 7; i++) begin
            g = 'x;
            if (i < q0.size()) g = q0[i];
            total++;
            if (g !== 16'sd0 || (i < qs0.size() && qs0[i] !== 1'b0)) begin
                bad++;
                $display("FAIL rstmid_y[%0d] got=%0d want=0", i, g);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; x_in = '0; flush = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        clear_stim();
        test_reset();
        test_impulse();
        test_bubbles();
        test_saturation();
        test_flush();
        test_coef_update();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
